// File: rtl/pc_flow_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_flow_ctrl_if
// Bundle of the signals between the instruction decoder / PC register and
// the program-counter flow sequencer.
//   master modport : decoder/PC side. It drives the run/halt/stall controls,
//                    the decoded op and its operands, and reads the PC
//                    controls and status.
//   slave modport  : sequencer side (pc_flow_ctrl).
// Signals
//   run, halt_req, mem_wait           execution control
//   instr_valid, op_jump, op_jz,
//   op_call, op_ret, zero_flag        decoded instruction and condition
//   target[15:0], cur_pc[15:0]        jump target and current instruction address
//   pc_load, pc_addr[15:0], pc_hold   PC control (PC <= pc_addr+1 on load)
//   state[1:0]                        IDLE=00 RUN=01 WAIT=10 HALT=11
//   stack_ovf, stack_unf              sticky stack error flags
//   retired[15:0]                     executed instruction counter
// ---------------------------------------------------------------------------
interface pc_flow_ctrl_if;
    logic        run;
    logic        halt_req;
    logic        mem_wait;
    logic        instr_valid;
    logic        op_jump;
    logic        op_jz;
    logic        zero_flag;
    logic        op_call;
    logic        op_ret;
    logic [15:0] target;
    logic [15:0] cur_pc;
    logic        pc_load;
    logic [15:0] pc_addr;
    logic        pc_hold;
    logic [1:0]  state;
    logic        stack_ovf;
    logic        stack_unf;
    logic [15:0] retired;

    modport master (
        output run, halt_req, mem_wait, instr_valid,
               op_jump, op_jz, zero_flag, op_call, op_ret,
               target, cur_pc,
        input  pc_load, pc_addr, pc_hold, state,
               stack_ovf, stack_unf, retired
    );

    modport slave (
        input  run, halt_req, mem_wait, instr_valid,
               op_jump, op_jz, zero_flag, op_call, op_ret,
               target, cur_pc,
        output pc_load, pc_addr, pc_hold, state,
               stack_ovf, stack_unf, retired
    );
endinterface

// File: rtl/pc_flow_ctrl.sv
// ---------------------------------------------------------------------------
// pc_flow_ctrl
// Program-counter flow sequencer. Each cycle it decides whether the 16-bit PC
// advances, holds or loads a new target. Handles jumps, zero-conditional
// jumps, call/return through an internal return-address stack, memory-wait
// stalls and halt.
// PC contract: pc_load=1 -> PC becomes pc_addr+1 at the next edge; otherwise
// PC holds when pc_hold=1 and increments when pc_hold=0. That is why every
// load address is presented as "destination - 1".
// Ports
//   clk     in  rising-edge clock
//   reset   in  asynchronous, active-high reset
//   bus     slave modport of pc_flow_ctrl_if (controls, op, PC outputs, status)
// Parameter
//   STACK_DEPTH  return-address stack entries (power of 2, 2..64)
// ---------------------------------------------------------------------------
module pc_flow_ctrl #(
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    pc_flow_ctrl_if.slave   bus
);
    localparam int AW  = $clog2(STACK_DEPTH);
    // One extra bit so the pointer can represent "full" (sp == STACK_DEPTH).
    localparam int SPW = AW + 1;
    localparam logic [SPW-1:0] SP_FULL = SPW'(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_WAIT = 2'b10,
        ST_HALT = 2'b11
    } state_t;

    state_t          state_reg, state_next;
    logic [SPW-1:0]  sp_reg, sp_next;
    logic            ovf_reg, ovf_next;
    logic            unf_reg, unf_next;
    logic [15:0]     retired_reg, retired_next;

    // Return-address storage. The top is read combinationally because a ret
    // must present the popped address in the same cycle it is decoded.
    logic [15:0]     stack_mem [STACK_DEPTH];
    logic [AW-1:0]   top_idx;
    logic            push_en;
    logic [15:0]     push_data;

    logic            load;
    logic [15:0]     addr;
    logic            hold;

    // When full, the low bits wrap to 0 and 0-1 gives STACK_DEPTH-1, which is
    // exactly the top entry, so no special case is needed.
    assign top_idx   = sp_reg[AW-1:0] - AW'(1);
    assign push_data = bus.cur_pc + 16'd1;

    // -----------------------------------------------------------------------
    // Next-state and PC-control decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        sp_next      = sp_reg;
        ovf_next     = ovf_reg;
        unf_next     = unf_reg;
        retired_next = retired_reg;
        push_en      = 1'b0;
        load         = 1'b0;
        addr         = 16'h0000;
        hold         = 1'b1;

        case (state_reg)
            ST_IDLE: begin
                if (bus.run) begin
                    state_next = ST_RUN;
                end
            end

            ST_RUN: begin
                if (bus.halt_req) begin
                    state_next = ST_HALT;
                end else if (bus.mem_wait) begin
                    // The decoder re-presents the instruction once memory is
                    // ready, so nothing is retired or acted on here.
                    state_next = ST_WAIT;
                end else begin
                    hold = 1'b0;
                    if (bus.instr_valid) begin
                        retired_next = retired_reg + 16'd1;
                        if (bus.op_ret) begin
                            if (sp_reg == '0) begin
                                // Freeze at the faulting instruction.
                                unf_next   = 1'b1;
                                state_next = ST_HALT;
                                hold       = 1'b1;
                            end else begin
                                sp_next = sp_reg - SPW'(1);
                                load    = 1'b1;
                                addr    = stack_mem[top_idx] - 16'd1;
                            end
                        end else if (bus.op_call) begin
                            if (sp_reg == SP_FULL) begin
                                ovf_next   = 1'b1;
                                state_next = ST_HALT;
                                hold       = 1'b1;
                            end else begin
                                push_en = 1'b1;
                                sp_next = sp_reg + SPW'(1);
                                load    = 1'b1;
                                addr    = bus.target - 16'd1;
                            end
                        end else if (bus.op_jz) begin
                            if (bus.zero_flag) begin
                                load = 1'b1;
                                addr = bus.target - 16'd1;
                            end
                        end else if (bus.op_jump) begin
                            load = 1'b1;
                            addr = bus.target - 16'd1;
                        end
                    end
                end
            end

            ST_WAIT: begin
                if (bus.halt_req) begin
                    state_next = ST_HALT;
                end else if (!bus.mem_wait) begin
                    state_next = ST_RUN;
                end
            end

            default: begin
                // HALT: only reset leaves; stack and flags are kept for debug.
                state_next = ST_HALT;
            end
        endcase

        if (load) begin
            hold = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            sp_reg      <= '0;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
            retired_reg <= 16'h0000;
        end else begin
            state_reg   <= state_next;
            sp_reg      <= sp_next;
            ovf_reg     <= ovf_next;
            unf_reg     <= unf_next;
            retired_reg <= retired_next;
        end
    end

    // Stack contents need no reset: emptiness is tracked by sp alone.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stack_mem[sp_reg[AW-1:0]] <= push_data;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs. Reset gates the combinational PC controls directly so a
    // pending load is dropped the moment reset rises, not at the next edge.
    // -----------------------------------------------------------------------
    assign bus.pc_load   = reset ? 1'b0     : load;
    assign bus.pc_addr   = reset ? 16'h0000 : addr;
    assign bus.pc_hold   = reset ? 1'b1     : hold;
    assign bus.state     = state_reg;
    assign bus.stack_ovf = ovf_reg;
    assign bus.stack_unf = unf_reg;
    assign bus.retired   = retired_reg;

endmodule
